uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_rx_sync_fifo.sv | 75 +++++++
 rtl/uart_rx_fifo.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and the
// legal OVERSAMPLE range.
package uart_rx_pkg;

  localparam int OVERSAMPLE_MIN = 8;
  localparam int OVERSAMPLE_MAX = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Synchronous show-ahead FIFO for received words.
// Handshake: i_rd_en pops the head at the next rising edge only while
// o_rd_valid is 1; o_rd_data always shows the current head (0 when empty).
// A write into a full FIFO is dropped and pulses o_overrun, unless a pop
// happens in the same cycle, in which case both the write and the pop occur.
module uart_rx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_rd_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overrun;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_LEVEL);
  assign w_pop   = i_rd_en && !w_empty;
  assign w_push  = i_wr_en && (!w_full || w_pop);

  // Storage array: written on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= i_wr_en && w_full && !w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_rd_valid = !w_empty;
  assign o_level    = r_count;
  assign o_overrun  = r_overrun;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampling tick generator and receive FIFO.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
// Frames: start(0), DATA_BITS data LSB first, [parity], stop(1).
// Every bit is sampled once, at tick OVERSAMPLE/2-1 within the bit.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [15:0]                   PRESCALE,
`ifdef UART_RX_PARITY_EN
  input  logic                          PARITY_ODD,
`endif
  input  logic                          RX,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output rx_state_t                     o_dbg_state
);

  // Out-of-range oversample values are clamped into the legal range.
  localparam int OVS = (OVERSAMPLE < OVERSAMPLE_MIN) ? OVERSAMPLE_MIN :
                       (OVERSAMPLE > OVERSAMPLE_MAX) ? OVERSAMPLE_MAX : OVERSAMPLE;
  localparam int SW = $clog2(OVERSAMPLE_MAX);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] SAMPLE_AT = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] LAST_SAMP = SW'(OVS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_rx_prev;
  rx_state_t            r_state;
  logic [15:0]          r_prescale;
  logic [15:0]          r_tick_cnt;
  logic [SW-1:0]        r_samp_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_push;
  logic                 r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bad;
  logic                 r_parity_err;
`endif

  logic w_rx;
  logic w_fall;
  logic w_tick;
  logic w_sample;

  assign w_rx     = r_sync2;
  assign w_fall   = r_rx_prev && !r_sync2;
  assign w_tick   = (r_tick_cnt == r_prescale);
  assign w_sample = w_tick && (r_samp_cnt == SAMPLE_AT);

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= RX;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // Oversample tick and sample counters; held at 0 while idle so a frame
  // always starts counting from a clean phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_tick_cnt <= '0;
      r_samp_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_tick_cnt <= '0;
      r_samp_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
      r_samp_cnt <= (r_samp_cnt == LAST_SAMP) ? '0 : r_samp_cnt + 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Frame FSM with registered push and error pulses.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state      <= IDLE;
      r_prescale   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_push       <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_prescale <= PRESCALE;
          r_bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
          r_par_bad  <= 1'b0;
`endif
          if (w_fall) begin
            r_state <= START;
          end
        end
        START: begin
          if (w_sample) begin
            r_state <= w_rx ? IDLE : DATA;
          end
        end
        DATA: begin
          if (w_sample) begin
            r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              r_state   <= PARITY;
`else
              r_state   <= STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (w_sample) begin
            if (w_rx != ((^r_shift) ^ PARITY_ODD)) begin
              r_par_bad    <= 1'b1;
              r_parity_err <= 1'b1;
            end
            r_state <= STOP;
          end
`else
          r_state <= IDLE;
`endif
        end
        STOP: begin
          if (w_sample) begin
            r_state <= IDLE;
            if (!w_rx) begin
              r_frame_err <= 1'b1;
            end else begin
`ifdef UART_RX_PARITY_EN
              r_push <= !r_par_bad;
`else
              r_push <= 1'b1;
`endif
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  uart_rx_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (HCLK),
    .rst        (HRESET),
    .i_wr_en    (r_push),
    .i_wr_data  (r_shift),
    .i_rd_en    (rd_en),
    .o_rd_data  (rd_data),
    .o_rd_valid (rd_valid),
    .o_level    (fifo_level),
    .o_overrun  (overrun)
  );

  assign frame_err   = r_frame_err;
  assign o_dbg_state = r_state;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = r_parity_err;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: random and directed frames checked against a
// frame-level reference model feeding an expected-word queue.
module tb_uart_rx_fifo;
  import uart_rx_pkg::*;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int OVERSAMPLE = 16;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic                 clk = 1'b0;
  logic                 rst;
  logic [15:0]          prescale;
  logic                 parity_odd;
  logic                 rx;
  logic                 rd_en;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic [LW-1:0]        fifo_level;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  rx_state_t            dbg_state;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .HCLK        (clk),
    .HRESET      (rst),
    .PRESCALE    (prescale),
`ifdef UART_RX_PARITY_EN
    .PARITY_ODD  (parity_odd),
`endif
    .RX          (rx),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fifo_level  (fifo_level),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun     (overrun),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_BITS-1:0] exp_q[$];
  logic [DATA_BITS-1:0] exp_b;
  int exp_frame = 0, exp_par = 0, exp_ovr = 0;
  int got_frame = 0, got_par = 0, got_ovr = 0;
  bit reader_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: decides a frame's fate from its bits alone.
  function automatic void model_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    bit par_bad;
    par_bad = PAR_EN && (par_b != ((^d) ^ parity_odd));
    if (par_bad) exp_par++;
    if (!stop_b) begin
      exp_frame++;
    end else if (!par_bad) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(d);
      else exp_ovr++;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat ((int'(prescale) + 1) * OVERSAMPLE - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b, input bit model);
    if (model) model_frame(d, stop_b, par_b);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par_b);
    drive_bit(stop_b);
    drive_bit(1'b1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_err_cnt"}, got_frame, exp_frame);
    check({tag, "_parity_err_cnt"}, got_par, exp_par);
    check({tag, "_overrun_cnt"}, got_ovr, exp_ovr);
  endtask

  task automatic drain(input string tag);
    reader_on = 1'b1;
    for (int i = 0; i < 500 && (exp_q.size() != 0 || rd_valid); i++) @(negedge clk);
    reader_on = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_drain_valid"}, rd_valid, 0);
    check({tag, "_drain_level"}, fifo_level, 0);
    check({tag, "_drain_pending"}, exp_q.size(), 0);
  endtask

  // Reader: random pops while enabled.
  initial begin
    rd_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rd_en = reader_on && ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor: counts error pulses and compares every popped word.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err)  got_frame++;
      if (parity_err) got_par++;
      if (overrun)    got_ovr++;
      if (rd_en && rd_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got 0x%0h, expected no word", rd_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("pop_data", rd_data, exp_b);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    logic [7:0] d;
    logic       sb;
    logic       pb;

    rst = 1'b1; rx = 1'b1; prescale = 16'd0; parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, IDLE);
    check("rst_valid", rd_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_data", rd_data, 0);
    check("rst_pulses", {frame_err, parity_err, overrun}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single frame 0xA5 at PRESCALE=0, latency from start-bit drive.
    fork
      send_frame(8'hA5, 1'b1, (^8'hA5) ^ parity_odd, 1'b1);
      begin
        cyc = 0;
        wait (rx === 1'b0);
        while (!rd_valid && cyc < 300) begin
          @(negedge clk);
          cyc++;
        end
        n_checks++;
        if (cyc > 166) begin
          n_fail++;
          $display("FAIL a5_latency: got %0d cycles, expected <= 166", cyc);
        end
        check("a5_data", rd_data, 8'hA5);
        check("a5_level", fifo_level, 1);
      end
    join
    check_counts("a5");
    drain("a5");

    // False start: 3 low cycles.
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    check("false_start_entered", dbg_state, START);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("false_start_idle", dbg_state, IDLE);
    check("false_start_level", fifo_level, 0);
    check_counts("false_start");

    // Bad stop bit.
    send_frame(8'h3C, 1'b0, (^8'h3C) ^ parity_odd, 1'b1);
    check("frame_err_level", fifo_level, 0);
    check("frame_err_valid", rd_valid, 0);
    check_counts("frame_err");

    // Overrun: five words, no reads.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, (^8'(i)) ^ parity_odd, 1'b1);
    check("ovr_level_full", fifo_level, FIFO_DEPTH);
    check("ovr_head", rd_data, 8'h01);
    check_counts("ovr");
    drain("ovr");

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b1;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    check("par_bad_level", fifo_level, 0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    check("par_good_level", fifo_level, 1);
    check_counts("parity");
    drain("parity");
    parity_odd = 1'b0;
`endif

    // Reset during data bit 4 of 0x5A, then 0x81.
    fork
      send_frame(8'h5A, 1'b1, (^8'h5A) ^ parity_odd, 1'b0);
      begin
        repeat (1 + 4 * OVERSAMPLE + OVERSAMPLE + OVERSAMPLE / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_state", dbg_state, IDLE);
        check("midrst_valid", rd_valid, 0);
        check("midrst_data", rd_data, 0);
      end
    join
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("postrst_state", dbg_state, IDLE);
    send_frame(8'h81, 1'b1, (^8'h81) ^ parity_odd, 1'b1);
    check("postrst_level", fifo_level, 1);
    drain("postrst");
    check_counts("postrst");

    // Random frames with a random reader and random PRESCALE.
    reader_on = 1'b1;
    for (int n = 0; n < 16; n++) begin
      prescale   = 16'($urandom_range(0, 2));
      parity_odd = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 5) != 0);
      pb = ((^d) ^ parity_odd) ^ ($urandom_range(0, 4) == 0);
      send_frame(d, sb, pb, 1'b1);
    end
    drain("random");
    check_counts("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
